// File: rtl/msu_sd_arbiter.sv
// msu_sd_arbiter
//   Shares the single HPS SD sector port between the MSU data track (port 0)
//   and the MSU audio streamer (port 1). Round-robin arbitration with an
//   audio-urgent override, sector word counting and an ack timeout.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   req0/lba0           : data track sector request and address
//   ack0/buff_wr0/done0 : data track ack mirror, word strobe, end-of-sector pulse
//   req1/lba1           : audio sector request and address
//   ack1/buff_wr1/done1 : audio ack mirror, word strobe, end-of-sector pulse
//   audio_urgent        : audio FIFO low; port 1 wins arbitration outright
//   sd_rd/sd_lba        : sector read request and address to the HPS
//   sd_ack/sd_buff_wr   : HPS transfer-active flag and word strobe
//   grant               : one-hot current owner (01 data, 10 audio, 00 none)
//   word_cnt            : words received in the current sector
//   timeout_err/len_err : sticky error flags, cleared only by reset
module msu_sd_arbiter #(
   parameter int unsigned LBA_W          = 21,
   parameter int unsigned SECTOR_WORDS   = 256,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [LBA_W-1:0] lba0,
   output logic             ack0,
   output logic             buff_wr0,
   output logic             done0,
   input  logic             req1,
   input  logic [LBA_W-1:0] lba1,
   output logic             ack1,
   output logic             buff_wr1,
   output logic             done1,
   input  logic             audio_urgent,
   output logic             sd_rd,
   output logic [LBA_W-1:0] sd_lba,
   input  logic             sd_ack,
   input  logic             sd_buff_wr,
   output logic [1:0]       grant,
   output logic [8:0]       word_cnt,
   output logic             timeout_err,
   output logic             len_err
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_e;

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic [LBA_W-1:0] lba_q, lba_d;
   logic             rd_q, rd_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [8:0]       wcnt_q, wcnt_d;
   logic             last_q, last_d;
   logic [1:0]       done_q, done_d;
   logic [1:0]       ack_q, ack_d;
   logic [1:0]       bwr_q, bwr_d;
   logic             terr_q, terr_d;
   logic             lerr_q, lerr_d;
   logic             win_v, win_p;

   // Winner selection: urgent audio first, then a lone requester, then
   // whichever port was not served last.
   always_comb begin
      win_v = 1'b0;
      win_p = 1'b0;
      if (req1 && audio_urgent) begin
         win_v = 1'b1;
         win_p = 1'b1;
      end else if (req0 && req1) begin
         win_v = 1'b1;
         win_p = ~last_q;
      end else if (req0 || req1) begin
         win_v = 1'b1;
         win_p = req1;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      lba_d   = lba_q;
      rd_d    = rd_q;
      timer_d = timer_q;
      wcnt_d  = wcnt_q;
      last_d  = last_q;
      done_d  = '0;
      terr_d  = terr_q;
      lerr_d  = lerr_q;
      // Mirrors go only to the current owner; strobes only count in XFER.
      ack_d   = {sd_ack & grant_q[1], sd_ack & grant_q[0]};
      bwr_d   = (state_q == XFER && sd_buff_wr) ? grant_q : 2'b00;

      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            if (win_v) begin
               grant_d = win_p ? 2'b10 : 2'b01;
               lba_d   = win_p ? lba1 : lba0;
               rd_d    = 1'b1;
               timer_d = '0;
               wcnt_d  = '0;
               last_d  = win_p;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (sd_ack) begin
               rd_d    = 1'b0;
               state_d = XFER;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               rd_d    = 1'b0;
               terr_d  = 1'b1;
               done_d  = grant_q;
               grant_d = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         XFER: begin
            if (sd_buff_wr && wcnt_q != 9'(SECTOR_WORDS))
               wcnt_d = wcnt_q + 1'b1;
            if (!sd_ack) begin
               done_d  = grant_q;
               grant_d = '0;
               if (wcnt_d != 9'(SECTOR_WORDS))
                  lerr_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         lba_q   <= '0;
         rd_q    <= 1'b0;
         timer_q <= '0;
         wcnt_q  <= '0;
         last_q  <= 1'b1;
         done_q  <= '0;
         ack_q   <= '0;
         bwr_q   <= '0;
         terr_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         lba_q   <= lba_d;
         rd_q    <= rd_d;
         timer_q <= timer_d;
         wcnt_q  <= wcnt_d;
         last_q  <= last_d;
         done_q  <= done_d;
         ack_q   <= ack_d;
         bwr_q   <= bwr_d;
         terr_q  <= terr_d;
         lerr_q  <= lerr_d;
      end
   end

   assign ack0        = ack_q[0];
   assign ack1        = ack_q[1];
   assign buff_wr0    = bwr_q[0];
   assign buff_wr1    = bwr_q[1];
   assign done0       = done_q[0];
   assign done1       = done_q[1];
   assign sd_rd       = rd_q;
   assign sd_lba      = lba_q;
   assign grant       = grant_q;
   assign word_cnt    = wcnt_q;
   assign timeout_err = terr_q;
   assign len_err     = lerr_q;

endmodule

// File: doc/msu_sd_arbiter.md
Name: msu_sd_arbiter

Overview:
Shares the single HPS SD sector port between two MSU requesters: port 0 for the MSU data track and port 1 for the MSU audio streamer. It grants one requester at a time and drives sd_rd/sd_lba on the winner's behalf. It routes sd_ack and sd_buff_wr back to the winner only, and supervises each sector transfer with a word count and an ack timeout. Arbitration is round-robin, with an urgent override for audio when the audio FIFO is running low.

Parameters:
LBA_W, 21, sector address width.
SECTOR_WORDS, 256, 16-bit words per sector (512 B).
TIMEOUT_CYCLES, 1000000, cycles allowed from sd_rd assertion to sd_ack rising edge.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-low reset.
req0  input  1  data requester wants a sector; held high until ack0 is seen.
lba0  input  LBA_W  data sector address; stable while req0 is high.
ack0  output  1  equals sd_ack while port 0 is granted, else 0.
buff_wr0  output  1  equals sd_buff_wr while port 0 is granted and in XFER, else 0.
done0  output  1  one-cycle pulse when a port 0 transfer ends.
req1, lba1, ack1, buff_wr1, done1: same as above, for audio port 1.
audio_urgent  input  1  audio FIFO below its low-water mark; gives port 1 absolute priority.
sd_rd  output  1  sector read request to HPS.
sd_lba  output  LBA_W  sector address to HPS.
sd_ack  input  1  HPS transfer-active flag.
sd_buff_wr  input  1  HPS word strobe.
grant  output  2  one-hot current owner: 01 = data, 10 = audio, 00 = none.
word_cnt  output  9  words received in the current sector.
timeout_err  output  1  sticky; set when the ack timeout expires.
len_err  output  1  sticky; set when a sector ends with word_cnt != SECTOR_WORDS.

Behaviour:
- All outputs are registered.
- Reset (reset == 0, sampled at clk) drives every output to 0, sets state to IDLE and last_grant to 1 (audio), and clears the timeout counter. This applies mid-transfer too: sd_rd drops on the next edge, and no done pulse is issued.
- State IDLE:
  - With no requests: grant = 00.
  - Winner selection: if req1 && audio_urgent, port 1 wins. Else if exactly one req is high, that port wins. Else if both are high, the port != last_grant wins.
  - On a win, on the next edge: grant <= winner, sd_lba <= lba of winner, sd_rd <= 1, timer <= 0, word_cnt <= 0, last_grant <= winner; go to ISSUE.
  - Latency is one cycle from req to sd_rd.
- State ISSUE:
  - Timer increments each cycle.
  - If sd_ack == 1: sd_rd <= 0; go to XFER. The ack_x mirror is combinational-through-register, so ack_x rises one cycle after sd_ack.
  - If the timer reaches TIMEOUT_CYCLES - 1 without sd_ack: sd_rd <= 0, timeout_err <= 1, pulse done_x, grant <= 00; go to IDLE.
  - The requester's req stays high after a timeout, so the sector is retried under normal arbitration.
- State XFER:
  - Each sd_buff_wr increments word_cnt; it saturates at SECTOR_WORDS, and extra strobes are forwarded but not counted.
  - On sd_ack falling (sd_ack == 0 sampled in XFER): pulse done_x for one cycle, grant <= 00, go to IDLE.
  - If word_cnt != SECTOR_WORDS at that point, len_err <= 1.
- Turnaround: at least one IDLE cycle separates consecutive grants (done pulse cycle).
- Routing:
  - buff_wr_x and ack_x of the non-granted port are held at 0.
  - sd_buff_wr outside XFER is ignored.
- Requests:
  - A request dropped before grant is simply not served.
  - req/lba changes while granted are ignored, because sd_lba is latched at grant.
- audio_urgent only affects selection in IDLE; it never pre-empts an active transfer.
- timeout_err and len_err clear only on reset.

Test Plan:
- Single data request: req0 = 1, lba0 = 0x00010. Expect sd_rd = 1 and sd_lba = 0x00010 one cycle later, with grant = 01. HPS acks and sends 256 strobes: buff_wr0 pulses 256 times, buff_wr1 stays 0. On ack fall: done0 pulses once, word_cnt = 256, len_err = 0.
- Both requesting, audio_urgent = 0, from reset: grant order is 01, 10, 01, 10 over four back-to-back sectors, with one IDLE cycle between each.
- Both requesting, audio_urgent = 1: port 1 wins three consecutive sectors. Drop urgent: the next grant goes to port 0.
- Timeout: req1 = 1, HPS never acks, TIMEOUT_CYCLES set to 50 in the bench. Expect sd_rd to fall after 50 cycles, timeout_err = 1, done1 pulsed. The request is re-issued with sd_rd high again two cycles later.
- Short sector: HPS sends 200 strobes and then drops sd_ack. Expect word_cnt = 200, len_err = 1, done pulsed.
- Reset mid-XFER after 100 words: expect sd_rd = 0, grant = 00, word_cnt = 0 and no done pulse. After reset releases, req0 is granted normally.
